// File: rtl/ysyx_idu_queue_pkg.sv
// Shared types for the IDU instruction queue: stored entry layout and pointer width.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

package ysyx_idu_queue_pkg;

  localparam int unsigned IDU_QDEPTH = 8;
  localparam int unsigned IDU_QPTR_W = $clog2(IDU_QDEPTH);

  typedef struct packed {
    logic [31:0]            inst;
    logic [`YSYX_XLEN-1:0]  pc;
    logic [`YSYX_XLEN-1:0]  pnpc;
    logic                   trap;
    logic [`YSYX_XLEN-1:0]  cause;
  } idu_qentry_t;

endpackage

// File: rtl/ysyx_idu_decoder_c.sv
// RV32C expander: maps a 16-bit compressed instruction to its 32-bit equivalent.
// Reserved or unsupported encodings expand to all-zero, which decodes as illegal downstream.
module ysyx_idu_decoder_c (
  input  logic [15:0] rvc,
  output logic [31:0] inst
);

  logic [4:0] rd, rs2, p42, p97;

  always_comb begin
    rd   = rvc[11:7];
    rs2  = rvc[6:2];
    p42  = {2'b01, rvc[4:2]};
    p97  = {2'b01, rvc[9:7]};
    inst = '0;
    case ({rvc[15:13], rvc[1:0]})
      5'b000_00: if (rvc[12:5] != 8'd0)
                   inst = {2'b00, rvc[10:7], rvc[12:11], rvc[5], rvc[6], 2'b00, 5'd2, 3'b000, p42, 7'b0010011};
      5'b010_00: inst = {5'b0, rvc[5], rvc[12:10], rvc[6], 2'b00, p97, 3'b010, p42, 7'b0000011};
      5'b110_00: inst = {5'b0, rvc[5], rvc[12], p42, p97, 3'b010, rvc[11:10], rvc[6], 2'b00, 7'b0100011};
      5'b000_01: inst = {{7{rvc[12]}}, rvc[6:2], rd, 3'b000, rd, 7'b0010011};
      5'b001_01,
      5'b101_01: inst = {rvc[12], rvc[8], rvc[10:9], rvc[6], rvc[7], rvc[2], rvc[11], rvc[5:3],
                         rvc[12], {8{rvc[12]}}, 4'b0000, ~rvc[15], 7'b1101111};
      5'b010_01: inst = {{7{rvc[12]}}, rvc[6:2], 5'd0, 3'b000, rd, 7'b0010011};
      5'b011_01: begin
        if ({rvc[12], rvc[6:2]} == 6'd0)
          inst = '0;
        else if (rd == 5'd2)
          inst = {{3{rvc[12]}}, rvc[4:3], rvc[5], rvc[2], rvc[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'b0010011};
        else
          inst = {{15{rvc[12]}}, rvc[6:2], rd, 7'b0110111};
      end
      5'b100_01: begin
        case (rvc[11:10])
          2'b00: inst = {6'b000000, rvc[12], rvc[6:2], p97, 3'b101, p97, 7'b0010011};
          2'b01: inst = {6'b010000, rvc[12], rvc[6:2], p97, 3'b101, p97, 7'b0010011};
          2'b10: inst = {{7{rvc[12]}}, rvc[6:2], p97, 3'b111, p97, 7'b0010011};
          default: begin
            if (!rvc[12]) begin
              case (rvc[6:5])
                2'b00:   inst = {7'b0100000, p42, p97, 3'b000, p97, 7'b0110011};
                2'b01:   inst = {7'b0000000, p42, p97, 3'b100, p97, 7'b0110011};
                2'b10:   inst = {7'b0000000, p42, p97, 3'b110, p97, 7'b0110011};
                default: inst = {7'b0000000, p42, p97, 3'b111, p97, 7'b0110011};
              endcase
            end
          end
        endcase
      end
      5'b110_01,
      5'b111_01: inst = {{4{rvc[12]}}, rvc[6:5], rvc[2], 5'd0, p97, 2'b00, rvc[13],
                         rvc[11:10], rvc[4:3], rvc[12], 7'b1100011};
      5'b000_10: inst = {6'b000000, rvc[12], rvc[6:2], rd, 3'b001, rd, 7'b0010011};
      5'b010_10: inst = {4'b0, rvc[3:2], rvc[12], rvc[6:4], 2'b00, 5'd2, 3'b010, rd, 7'b0000011};
      5'b100_10: begin
        if (!rvc[12])
          inst = (rs2 == 5'd0) ? {12'b0, rd, 3'b000, 5'd0, 7'b1100111}
                               : {7'b0, rs2, 5'd0, 3'b000, rd, 7'b0110011};
        else if (rs2 == 5'd0)
          inst = (rd == 5'd0) ? 32'h0010_0073 : {12'b0, rd, 3'b000, 5'd1, 7'b1100111};
        else
          inst = {7'b0, rs2, rd, 3'b000, rd, 7'b0110011};
      end
      5'b110_10: inst = {4'b0, rvc[8:7], rvc[12], rs2, 5'd2, 3'b010, rvc[11:9], 2'b00, 7'b0100011};
      default:   inst = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_idu_queue_ram.sv
// Entry storage for the IDU queue: W write ports, W asynchronous read ports.
module ysyx_idu_queue_ram
  import ysyx_idu_queue_pkg::*;
#(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = IDU_QDEPTH,
  parameter int unsigned PTR_W = IDU_QPTR_W
) (
  input  logic                         clock,
  input  logic [W-1:0]                 wr_en,
  input  logic [W-1:0][PTR_W-1:0]      wr_addr,
  input  idu_qentry_t [W-1:0]          wr_data,
  input  logic [W-1:0][PTR_W-1:0]      rd_addr,
  output idu_qentry_t [W-1:0]          rd_data
);

  idu_qentry_t mem [DEPTH];

  // Write addresses within one cycle are always distinct, so port order is irrelevant.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < W; i++) begin
      if (wr_en[i]) mem[wr_addr[i]] <= wr_data[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < W; i++) rd_data[i] = mem[rd_addr[i]];
  end

endmodule

// File: rtl/ysyx_idu_queue.sv
// W-wide fetch-to-decode instruction queue with per-lane RVC expansion.
// Optional same-cycle bypass when empty: define YSYX_IDU_QUEUE_BYPASS_EN.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_idu_queue
  import ysyx_idu_queue_pkg::*;
#(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = `YSYX_XLEN
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_pipe,
  input  logic [W-1:0]             in_valid,
  output logic                     in_ready,
  input  logic [W*32-1:0]          in_inst,
  input  logic [W*XLEN-1:0]        in_pc,
  input  logic [W*XLEN-1:0]        in_pnpc,
  input  logic [W-1:0]             in_trap,
  input  logic [W*XLEN-1:0]        in_cause,
  output logic [W-1:0]             out_valid,
  output logic [W*32-1:0]          out_inst,
  output logic [W*32-1:0]          out_raw,
  output logic [W-1:0]             out_is_c,
  output logic [W*XLEN-1:0]        out_pc,
  output logic [W*XLEN-1:0]        out_pnpc,
  output logic [W-1:0]             out_trap,
  output logic [W*XLEN-1:0]        out_cause,
  output logic [W*XLEN-1:0]        out_tval,
  input  logic [$clog2(W+1)-1:0]   deq_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned DQ_W  = $clog2(W + 1);

  function automatic logic [DQ_W-1:0] popcount(input logic [W-1:0] v);
    popcount = '0;
    for (int unsigned i = 0; i < W; i++) popcount = popcount + DQ_W'(v[i]);
  endfunction

  logic [PTR_W-1:0]           head, tail;
  logic [CNT_W-1:0]           count;
  logic [DQ_W-1:0]            enq_n, skip;
  logic [W-1:0]               wr_en, lane_valid;
  logic [W-1:0][PTR_W-1:0]    wr_addr, rd_addr;
  idu_qentry_t [W-1:0]        in_entry, rd_entry, lane_entry;
  logic [31:0]                exp_inst [W];

`ifdef YSYX_IDU_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass = (count == '0) && !flush_pipe;
`endif

  assign in_ready = count <= CNT_W'(DEPTH - W);

  // With bypass, lanes consumed directly from the input are never written; the rest
  // are packed down to tail so storage stays contiguous.
  always_comb begin
    enq_n = in_ready ? popcount(in_valid) : '0;
    skip  = '0;
`ifdef YSYX_IDU_QUEUE_BYPASS_EN
    if (bypass) skip = deq_cnt;
`endif
    for (int unsigned i = 0; i < W; i++) begin
      in_entry[i] = '{inst:  in_inst[i*32 +: 32],
                      pc:    in_pc[i*XLEN +: XLEN],
                      pnpc:  in_pnpc[i*XLEN +: XLEN],
                      trap:  in_trap[i],
                      cause: in_cause[i*XLEN +: XLEN]};
      wr_en[i]   = !flush_pipe && (DQ_W'(i) < enq_n) && (DQ_W'(i) >= skip);
      wr_addr[i] = tail + PTR_W'(i) - PTR_W'(skip);
      rd_addr[i] = head + PTR_W'(i);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_pipe) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PTR_W'(enq_n) - PTR_W'(skip);
      head  <= head + PTR_W'(deq_cnt) - PTR_W'(skip);
      count <= count + CNT_W'(enq_n) - CNT_W'(deq_cnt);
    end
  end

  ysyx_idu_queue_ram #(
    .W     (W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (in_entry),
    .rd_addr (rd_addr),
    .rd_data (rd_entry)
  );

  for (genvar g = 0; g < W; g++) begin : g_rvc
    ysyx_idu_decoder_c u_dec (
      .rvc  (lane_entry[g].inst[15:0]),
      .inst (exp_inst[g])
    );
  end

  always_comb begin
    lane_entry = rd_entry;
    for (int unsigned i = 0; i < W; i++) lane_valid[i] = CNT_W'(i) < count;
`ifdef YSYX_IDU_QUEUE_BYPASS_EN
    if (bypass) begin
      lane_valid = in_valid & {W{in_ready}};
      lane_entry = in_entry;
    end
`endif
    out_valid = lane_valid;
    for (int unsigned i = 0; i < W; i++) begin
      out_is_c[i]              = lane_entry[i].inst[1:0] != 2'b11;
      out_raw[i*32 +: 32]      = lane_entry[i].inst;
      out_inst[i*32 +: 32]     = out_is_c[i] ? exp_inst[i] : lane_entry[i].inst;
      out_pc[i*XLEN +: XLEN]   = lane_entry[i].pc;
      out_pnpc[i*XLEN +: XLEN] = lane_entry[i].pnpc;
      out_trap[i]              = lane_entry[i].trap;
      out_cause[i*XLEN +: XLEN] = lane_entry[i].trap ? lane_entry[i].cause : '0;
      out_tval[i*XLEN +: XLEN]  = lane_entry[i].trap ? lane_entry[i].pc : '0;
    end
  end

  deq_within_visible: assert property (@(posedge clock) disable iff (!reset)
    deq_cnt <= popcount(out_valid));

endmodule
